// File: rtl/norm_sched_if.sv
// rtl/norm_sched_if.sv - requester, normalize-unit and result signals of norm_sched
interface norm_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [48*NREQ-1:0] req_vec;
    logic [NREQ-1:0]    req_ready;
    logic               norm_en;
    logic [47:0]        norm_vec;
    logic [47:0]        norm_vec_n;
    logic               norm_valid;
    logic               res_valid;
    logic               res_ready;
    logic [47:0]        res_vec;
    logic [2:0]         res_id;
    logic               res_err;
    logic               busy;

    modport master (
        output req_valid, req_vec, norm_vec_n, norm_valid, res_ready,
        input  req_ready, norm_en, norm_vec, res_valid, res_vec, res_id, res_err, busy
    );

    modport slave (
        input  req_valid, req_vec, norm_vec_n, norm_valid, res_ready,
        output req_ready, norm_en, norm_vec, res_valid, res_vec, res_id, res_err, busy
    );
endinterface

// File: rtl/norm_sched.sv
// rtl/norm_sched.sv - round-robin scheduler sharing one fp16 vector normalize unit
// Optional WAIT abort counter enabled by defining NORM_SCHED_TIMEOUT_EN.
module norm_sched #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        areset,
    norm_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [2:0]      ptr;
    logic [NREQ-1:0] grant_oh;
    logic [2:0]      grant_id;
    logic            grant_any;
    logic [47:0]     grant_vec;
    logic            grant_zero;
    logic [47:0]     norm_vec_q;
    logic [47:0]     res_vec_q;
    logic [2:0]      res_id_q;
    logic            res_valid_q;
    logic            norm_en_c;
    logic            busy_c;
    logic            timed_out;

    // Two passes give round-robin priority: indices at/after ptr first, then the wrap-around.
    always_comb begin
        grant_oh  = '0;
        grant_id  = 3'd0;
        grant_any = 1'b0;
        grant_vec = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && bus.req_valid[i] && (3'(i) >= ptr)) begin
                grant_any   = 1'b1;
                grant_id    = 3'(i);
                grant_oh[i] = 1'b1;
                grant_vec   = bus.req_vec[48*i +: 48];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_any && bus.req_valid[i] && (3'(i) < ptr)) begin
                grant_any   = 1'b1;
                grant_id    = 3'(i);
                grant_oh[i] = 1'b1;
                grant_vec   = bus.req_vec[48*i +: 48];
            end
        end
    end

    assign grant_zero = (grant_vec[46:32] == 15'd0) && (grant_vec[30:16] == 15'd0) &&
                        (grant_vec[14:0] == 15'd0);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        norm_en_c = 1'b0;
        busy_c    = 1'b1;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (grant_any) begin
                    state_nxt = grant_zero ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                norm_en_c = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.norm_valid || timed_out) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand is captured at grant and left untouched until the next grant, so it
    // stays stable across both sampling points of the normalize unit.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr         <= 3'd0;
            norm_vec_q  <= '0;
            res_vec_q   <= '0;
            res_id_q    <= 3'd0;
            res_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        norm_vec_q <= grant_vec;
                        res_id_q   <= grant_id;
                        ptr        <= (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
                        if (grant_zero) begin
                            res_vec_q   <= '0;
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.norm_valid) begin
                        res_vec_q   <= bus.norm_vec_n;
                        res_valid_q <= 1'b1;
                    end else if (timed_out) begin
                        res_vec_q   <= '0;
                        res_valid_q <= 1'b1;
                    end
                end
                OUT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NORM_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    assign timed_out = (state == WAIT) && !bus.norm_valid && (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if ((state == WAIT) && !bus.norm_valid) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if ((state == IDLE) && grant_any) begin
                err_q <= 1'b0;
            end else if (timed_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.res_err = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign timed_out          = 1'b0;
    assign bus.res_err        = 1'b0;
`endif

    // Grants are suppressed while reset is asserted even though state already reads IDLE.
    assign bus.req_ready = ((state == IDLE) && !areset) ? grant_oh : '0;
    assign bus.norm_en   = norm_en_c;
    assign bus.busy      = busy_c;
    assign bus.norm_vec  = norm_vec_q;
    assign bus.res_vec   = res_vec_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_valid = res_valid_q;
endmodule

// File: tb/tb_norm_sched.sv
// tb/tb_norm_sched.sv - table-driven scoreboard bench for norm_sched
`timescale 1ns/1ps
module tb_norm_sched;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 63;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    norm_sched_if #(.NREQ(NREQ)) bus ();
    norm_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [47:0] vec;
        logic [2:0]  id;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        int          id;
        logic [47:0] vec;
        logic [47:0] unit_res;
        int          lat;
    } vec_t;

    exp_t        sb[$];
    int          grant_log[$];
    vec_t        tbl[6];
    int          n_pass = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          exp_ptr = 0;
    int          n_grant = 0;
    int          unit_lat = 1;
    logic [47:0] unit_res = '0;
    logic [47:0] cur_op = '0;
    int          pend = 0;
    int          en_cnt = 0;
    int          stray_cnt = 0;
    int          stray_done = 0;
    bit          unit_fire = 0;
    bit          prev_rv = 0;
    bit          hold_chk = 0;
    logic [47:0] hold_vec = '0;
    logic [2:0]  hold_id = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic bit is_zero(input logic [47:0] v);
        return (v[46:32] == 15'd0) && (v[30:16] == 15'd0) && (v[14:0] == 15'd0);
    endfunction

    // Normalize-unit stand-in: answers unit_lat cycles after norm_en (0 = never answers).
    initial begin
        bus.norm_valid = 1'b0;
        bus.norm_vec_n = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.norm_valid = 1'b0;
            unit_fire = 0;
            if (areset) pend = 0;
            if (stray_cnt != stray_done) begin
                bus.norm_valid = 1'b1;
                bus.norm_vec_n = 48'hDEAD_BEEF_0001;
                stray_done++;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.norm_valid = 1'b1;
                    bus.norm_vec_n = unit_res;
                    unit_fire = 1;
                end
            end
            @(negedge clk);
            if (bus.norm_en) begin
                en_cnt++;
                if (unit_lat > 0) pend = unit_lat;
            end
        end
    end

    // One cycle: sample at negedge, then return at posedge+1 ready for new stimulus.
    task automatic tick();
        exp_t e;
        int   g;
        @(negedge clk);
        if (bus.req_ready != '0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (exp_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
            if (g < 0) begin
                check("grant_without_request", 64'(bus.req_ready), 64'd0);
            end else begin
                check("grant_onehot", 64'(bus.req_ready), 64'(1) << g);
                cur_op = bus.req_vec[48*g +: 48];
                e.id   = 3'(g);
                e.acc  = cyc;
                if (is_zero(cur_op)) begin
                    e.vec = '0; e.err = 0; e.lat = 1;
                end else if (unit_lat == 0) begin
                    e.vec = '0; e.err = 1; e.lat = TIMEOUT + 2;
                end else begin
                    e.vec = unit_res; e.err = 0; e.lat = unit_lat + 2;
                end
                sb.push_back(e);
                grant_log.push_back(g);
                exp_ptr = (g + 1) % NREQ;
                n_grant++;
            end
        end
        if (unit_fire && !areset) check("norm_vec_stable", 64'(bus.norm_vec), 64'(cur_op));
        if (bus.res_valid && !prev_rv && sb.size() > 0)
            check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        prev_rv = bus.res_valid;
        if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                check("res_vec", 64'(bus.res_vec), 64'(e.vec));
                check("res_id", 64'(bus.res_id), 64'(e.id));
                check("res_err", 64'(bus.res_err), 64'(e.err));
            end
        end
        if (hold_chk) begin
            check("hold_res_vec", 64'(bus.res_vec), 64'(hold_vec));
            check("hold_res_id", 64'(bus.res_id), 64'(hold_id));
            check("hold_busy", 64'(bus.busy), 64'(1));
            check("hold_no_grant", 64'(bus.req_ready), 64'(0));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int max);
        int n0;
        n0 = n_grant;
        for (int t = 0; t < max && n_grant == n0; t++) tick();
        check("grant_within_bound", 64'(n_grant != n0), 64'(1));
    endtask

    task automatic drain(input int max);
        for (int t = 0; t < max && (sb.size() != 0 || bus.busy); t++) tick();
        check("drain_within_bound", 64'(sb.size() == 0 && !bus.busy), 64'(1));
    endtask

    task automatic single(input int id, input logic [47:0] vec, input logic [47:0] res, input int lat);
        int en0;
        unit_lat = lat;
        unit_res = res;
        bus.req_vec[48*id +: 48] = vec;
        bus.req_valid = NREQ'(1 << id);
        bus.res_ready = 1'b1;
        en0 = en_cnt;
        wait_grant(20);
        bus.req_valid = '0;
        drain(300);
        check("norm_en_pulses", 64'(en_cnt - en0), is_zero(vec) ? 64'd0 : 64'd1);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        exp_ptr = 0;
        areset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 48'h3C00_0000_0000, 48'h3C00_0000_0000, 33};
        tbl[1] = '{2, 48'h8000_0000_0000, 48'h1111_2222_3333, 33};
        tbl[2] = '{1, 48'h4000_4000_0000, 48'h39A8_39A8_0000, 5};
        tbl[3] = '{3, 48'h8000_8000_8000, 48'h0000_0000_5555, 3};
        tbl[4] = '{3, 48'hBC00_0000_0000, 48'hBC00_0000_0000, 1};
        tbl[5] = '{1, 48'h0000_0000_0001, 48'h0000_0000_3C00, 2};

        areset        = 1'b1;
        bus.req_valid = '1;
        bus.req_vec   = {NREQ{48'h3C00_0000_0000}};
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_norm_en", 64'(bus.norm_en), 64'(0));
        check("rst_norm_vec", 64'(bus.norm_vec), 64'(0));
        check("rst_res_valid", 64'(bus.res_valid), 64'(0));
        check("rst_res_vec", 64'(bus.res_vec), 64'(0));
        check("rst_res_id", 64'(bus.res_id), 64'(0));
        check("rst_res_err", 64'(bus.res_err), 64'(0));
        bus.req_valid = '0;
        do_reset();

        for (int i = 0; i < 6; i++) single(tbl[i].id, tbl[i].vec, tbl[i].unit_res, tbl[i].lat);

        // All requesters held: rotation must run 0,1,2,3,0 from a fresh pointer.
        do_reset();
        unit_lat = 3;
        unit_res = 48'h3C00_3C00_3C00;
        for (int i = 0; i < NREQ; i++) bus.req_vec[48*i +: 48] = {16'h4000 + 16'(i), 32'h0};
        grant_log.delete();
        bus.req_valid = '1;
        bus.res_ready = 1'b1;
        for (int t = 0; t < 200 && grant_log.size() < 5; t++) tick();
        bus.req_valid = '0;
        drain(200);
        check("cont_grant_count", 64'(grant_log.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            if (i < grant_log.size()) check("cont_order", 64'(grant_log[i]), 64'(i % NREQ));

        // Backpressure with requester 0 waiting behind requester 1.
        unit_lat = 4;
        unit_res = 48'h0123_4567_89AB;
        bus.req_vec[48*1 +: 48] = 48'h3800_3800_3800;
        bus.req_vec[48*0 +: 48] = 48'h4400_0000_0000;
        bus.req_valid = 4'b0010;
        bus.res_ready = 1'b0;
        wait_grant(20);
        bus.req_valid = 4'b0001;
        for (int t = 0; t < 50 && !bus.res_valid; t++) tick();
        hold_vec = unit_res;
        hold_id  = 3'd1;
        hold_chk = 1;
        repeat (10) tick();
        hold_chk = 0;
        bus.res_ready = 1'b1;
        unit_res = 48'h3C00_0000_0000;
        wait_grant(20);
        check("waiting_req_served", 64'(grant_log[grant_log.size()-1]), 64'(0));
        bus.req_valid = '0;
        drain(100);

`ifdef NORM_SCHED_TIMEOUT_EN
        unit_lat = 0;
        bus.req_vec[48*2 +: 48] = 48'h4200_0000_0000;
        bus.req_valid = 4'b0100;
        wait_grant(20);
        bus.req_valid = '0;
        drain(300);
        stray_cnt++;
        repeat (4) tick();
        check("stray_ignored_busy", 64'(bus.busy), 64'(0));
        check("stray_ignored_valid", 64'(bus.res_valid), 64'(0));
        single(2, 48'h4200_0000_0000, 48'h3C00_0000_0000, 3);
`endif

        // Asynchronous reset in WAIT, then pointer must restart at requester 0.
        unit_lat = 40;
        unit_res = 48'h3C00_0000_0000;
        bus.req_vec[48*0 +: 48] = 48'h5000_0000_0000;
        bus.req_valid = 4'b0001;
        wait_grant(20);
        bus.req_valid = '0;
        repeat (10) tick();
        #2;
        areset = 1'b1;
        bus.req_valid = 4'b0011;
        #1;
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_norm_vec", 64'(bus.norm_vec), 64'(0));
        check("arst_res_valid", 64'(bus.res_valid), 64'(0));
        check("arst_req_ready", 64'(bus.req_ready), 64'(0));
        check("arst_norm_en", 64'(bus.norm_en), 64'(0));
        check("arst_res_vec", 64'(bus.res_vec), 64'(0));
        check("arst_res_err", 64'(bus.res_err), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        sb.delete();
        exp_ptr  = 0;
        prev_rv  = 0;
        areset   = 1'b0;
        unit_lat = 6;
        unit_res = 48'h3C00_0000_0000;
        wait_grant(20);
        check("post_reset_grant", 64'(grant_log[grant_log.size()-1]), 64'(0));
        bus.req_valid = '0;
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
